// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receiver: FSM states, counter widths
// and the three mid-bit sample positions as functions of the oversampling ratio.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BRKWAIT
  } uart_rx_state_t;

  localparam int S_W = $clog2(32);
  localparam int N_W = 4;

  function automatic logic [S_W-1:0] vote_lo(input int os);
    return S_W'(os / 2 - 1);
  endfunction

  function automatic logic [S_W-1:0] vote_mid(input int os);
    return S_W'(os / 2);
  endfunction

  // The vote completes on this tick, so all bit decisions happen here.
  function automatic logic [S_W-1:0] vote_hi(input int os);
    return S_W'(os / 2 + 1);
  endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchroniser resetting to 1 (idle level of a UART/CTS line).
import uart_pkg::*;

module uart_sync2 (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic q_o
);

  logic [1:0] sync_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], d_i};
    end
  end

  assign q_o = sync_q[1];

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver with majority vote, false-start and break handling,
// and a valid/ready output register. Parity bit enabled by UART_RX_PARITY_EN.
import uart_pkg::*;

module uart_rx_param #(
  parameter int DBIT       = 8,
  parameter int OVERSAMPLE = 16,
  parameter int STOP_BITS  = 1,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            rx,
  input  logic            s_tick,
  output logic [DBIT-1:0] rx_data,
  output logic            rx_valid,
  input  logic            rx_ready,
  output logic            frame_err,
  output logic            parity_err,
  output logic            overrun,
  output logic            busy
);

`ifdef UART_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  localparam logic [S_W-1:0] V_LO    = vote_lo(OVERSAMPLE);
  localparam logic [S_W-1:0] V_MID   = vote_mid(OVERSAMPLE);
  localparam logic [S_W-1:0] V_HI    = vote_hi(OVERSAMPLE);
  localparam logic [S_W-1:0] S_LAST  = S_W'(OVERSAMPLE - 1);
  localparam logic [N_W-1:0] N_DLAST = N_W'(DBIT - 1);
  localparam logic [N_W-1:0] N_SLAST = N_W'(STOP_BITS - 1);

  uart_rx_state_t  state_q, state_d;
  logic [S_W-1:0]  s_q, s_d;
  logic [N_W-1:0]  n_q, n_d;
  logic [DBIT-1:0] sh_q, sh_d;
  logic [1:0]      samp_q, samp_d;
  logic            ferr_q, ferr_d;
  logic            perr_q, perr_d;
  logic            stop1_q, stop1_d;
  logic            rx_s, vote, tick_hi, tick_end, complete, brk;

  logic [DBIT-1:0] data_q;
  logic            valid_q, valid_d;
  logic            fe_q, pe_q;
  logic            overrun_q, overrun_d;
  logic            busy_q, busy_d;
  logic            load;

  uart_sync2 u_sync (
    .clk   (clk),
    .reset (reset),
    .d_i   (rx),
    .q_o   (rx_s)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      s_q     <= '0;
      n_q     <= '0;
      sh_q    <= '0;
      samp_q  <= '0;
      ferr_q  <= 1'b0;
      perr_q  <= 1'b0;
      stop1_q <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      n_q     <= n_d;
      sh_q    <= sh_d;
      samp_q  <= samp_d;
      ferr_q  <= ferr_d;
      perr_q  <= perr_d;
      stop1_q <= stop1_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    s_d      = s_q;
    n_d      = n_q;
    sh_d     = sh_q;
    samp_d   = samp_q;
    ferr_d   = ferr_q;
    perr_d   = perr_q;
    stop1_d  = stop1_q;
    complete = 1'b0;
    brk      = 1'b0;
    vote     = (samp_q[0] & samp_q[1]) | (rx_s & (samp_q[0] | samp_q[1]));
    tick_hi  = s_tick && (s_q == V_HI);
    tick_end = s_tick && (s_q == S_LAST);

    if (s_tick && state_q != IDLE && state_q != BRKWAIT) begin
      s_d = tick_end ? '0 : s_q + 1'b1;
      if (s_q == V_LO)  samp_d[0] = rx_s;
      if (s_q == V_MID) samp_d[1] = rx_s;
    end

    case (state_q)
      IDLE: begin
        if (!rx_s) begin
          state_d = START;
          s_d     = '0;
          ferr_d  = 1'b0;
          perr_d  = 1'b0;
          stop1_d = 1'b0;
        end
      end
      START: begin
        if (tick_hi && vote) begin
          state_d = IDLE;
        end else if (tick_end) begin
          state_d = DATA;
          n_d     = '0;
        end
      end
      DATA: begin
        if (tick_hi) sh_d = {vote, sh_q[DBIT-1:1]};
        if (tick_end) begin
          n_d = n_q + 1'b1;
          if (n_q == N_DLAST) begin
            n_d     = '0;
            state_d = PAR_EN ? PARITY : STOP;
          end
        end
      end
      PARITY: begin
        if (tick_hi) perr_d = vote ^ (^sh_q) ^ PARITY_ODD;
        if (tick_end) begin
          state_d = STOP;
          n_d     = '0;
        end
      end
      STOP: begin
        if (tick_hi) begin
          ferr_d  = ferr_q | ~vote;
          stop1_d = stop1_q | vote;
          // Last stop bit completes at the vote, leaving half a bit of slack.
          if (n_q == N_SLAST) begin
            complete = 1'b1;
            brk      = (sh_q == '0) && !stop1_d;
            state_d  = brk ? BRKWAIT : IDLE;
          end
        end else if (tick_end) begin
          n_d = n_q + 1'b1;
        end
      end
      BRKWAIT: begin
        if (rx_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    load      = complete && (!valid_q || rx_ready);
    overrun_d = complete && !load;
    valid_d   = valid_q;
    if (load)          valid_d = 1'b1;
    else if (rx_ready) valid_d = 1'b0;
    busy_d    = (state_q != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q    <= '0;
      valid_q   <= 1'b0;
      fe_q      <= 1'b0;
      pe_q      <= 1'b0;
      overrun_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
      busy_q    <= busy_d;
      if (load) begin
        data_q <= sh_q;
        fe_q   <= ferr_d;
        pe_q   <= perr_q;
      end
    end
  end

  assign rx_data    = data_q;
  assign rx_valid   = valid_q;
  assign frame_err  = fe_q;
  assign parity_err = PAR_EN & pe_q;
  assign overrun    = overrun_q;
  assign busy       = busy_q;

endmodule
